busca_instrucao: RTL and testbench

Instruction-fetch stage of the MIPS datapath, sitting directly upstream of the control unit. It keeps the program counter, issues word fetches to instruction memory over a request/response interface, buffers returned words in a small prefetch FIFO, and presents them in order to decode with a valid/ready handshake. Decode receives `opCode` and `funct` straight from the FIFO head. A branch/jump redirect flushes the FIFO and discards in-flight responses.

---
 rtl/busca_instrucao_if.sv | 29 ++
 rtl/busca_instrucao.sv | 111 +++++++++++
 tb/tb_busca_instrucao.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/busca_instrucao_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the decode handshake and redirect.
// master = fetch stage, slave = memory/decode environment.
interface busca_instrucao_if #(
    parameter int LARGURA_PC = 32
);
    logic                  memReq;
    logic [LARGURA_PC-1:0] memEnd;
    logic                  memAceito;
    logic                  memValido;
    logic [31:0]           memDado;
    logic                  instrValida;
    logic [31:0]           instrucao;
    logic [LARGURA_PC-1:0] instrPC;
    logic [5:0]            opCode;
    logic [5:0]            funct;
    logic                  decPronto;
    logic                  desvio;
    logic [LARGURA_PC-1:0] alvoDesvio;

    modport master (
        output memReq, memEnd, instrValida, instrucao, instrPC, opCode, funct,
        input  memAceito, memValido, memDado, decPronto, desvio, alvoDesvio
    );

    modport slave (
        input  memReq, memEnd, instrValida, instrucao, instrPC, opCode, funct,
        output memAceito, memValido, memDado, decPronto, desvio, alvoDesvio
    );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch: PC, credit-limited memory requests, prefetch FIFO feeding decode in order.
// Latency: accept in N -> instrValida in N+2; decode stall holds the head stable and stops requests once credits run out.
// Optional BUSCA_CONTADORES_EN adds contInstr = {dropped responses, pops}, each 16-bit saturating.
module busca_instrucao #(
    parameter int                    LARGURA_PC   = 32,
    parameter int                    PROFUNDIDADE = 4,
    parameter logic [LARGURA_PC-1:0] PC_INICIAL   = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    busca_instrucao_if.master   bus
`ifdef BUSCA_CONTADORES_EN
    ,
    output logic [31:0]         contInstr
`endif
);
    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int CW = PW + 1;

    logic [LARGURA_PC-1:0] pc;
    logic [LARGURA_PC-1:0] pcResp;
    logic [31:0]           filaPalavra [PROFUNDIDADE];
    logic [LARGURA_PC-1:0] filaPC      [PROFUNDIDADE];
    logic [PW-1:0]         rdPtr;
    logic [PW-1:0]         wrPtr;
    logic [CW-1:0]         ocupacao;
    logic [CW-1:0]         pendentes;
    logic [CW-1:0]         descartar;
    logic [CW:0]           creditoUsado;
    logic                  transfere;
    logic                  descarta;
    logic                  empurra;
    logic                  retira;
    logic [LARGURA_PC-1:0] alvo;

    // Credits count both buffered words and words still owed by memory, so a push never overflows.
    assign creditoUsado = {1'b0, ocupacao} + {1'b0, pendentes};
    assign bus.memReq   = reset_n && !bus.desvio && (creditoUsado < (CW+1)'(PROFUNDIDADE));
    assign bus.memEnd   = pc;
    assign transfere    = bus.memReq && bus.memAceito;
    assign descarta     = bus.memValido && (bus.desvio || (descartar != '0));
    assign empurra      = bus.memValido && !descarta;
    assign retira       = bus.instrValida && bus.decPronto;
    assign alvo         = {bus.alvoDesvio[LARGURA_PC-1:2], 2'b00};

    assign bus.instrValida = (ocupacao != '0);
    assign bus.instrucao   = bus.instrValida ? filaPalavra[rdPtr] : 32'h0;
    assign bus.instrPC     = bus.instrValida ? filaPC[rdPtr] : '0;
    assign bus.opCode      = bus.instrucao[31:26];
    assign bus.funct       = bus.instrucao[5:0];

    // pcResp tracks the address of the next response that will be kept; responses arrive in order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= PC_INICIAL;
            pcResp    <= PC_INICIAL;
            rdPtr     <= '0;
            wrPtr     <= '0;
            ocupacao  <= '0;
            pendentes <= '0;
            descartar <= '0;
        end else if (bus.desvio) begin
            pc        <= alvo;
            pcResp    <= alvo;
            rdPtr     <= '0;
            wrPtr     <= '0;
            ocupacao  <= '0;
            pendentes <= pendentes - CW'(bus.memValido);
            descartar <= pendentes - CW'(bus.memValido);
        end else begin
            if (transfere)
                pc <= pc + LARGURA_PC'(4);
            if (empurra) begin
                wrPtr  <= wrPtr + PW'(1);
                pcResp <= pcResp + LARGURA_PC'(4);
            end
            if (retira)
                rdPtr <= rdPtr + PW'(1);
            if (descarta)
                descartar <= descartar - CW'(1);
            ocupacao  <= ocupacao + CW'(empurra) - CW'(retira);
            pendentes <= pendentes + CW'(transfere) - CW'(bus.memValido);
        end
    end

    always_ff @(posedge clk) begin
        if (empurra) begin
            filaPalavra[wrPtr] <= bus.memDado;
            filaPC[wrPtr]      <= pcResp;
        end
    end

`ifdef BUSCA_CONTADORES_EN
    logic [15:0] contPop;
    logic [15:0] contDesc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            contPop  <= '0;
            contDesc <= '0;
        end else begin
            if (retira && contPop != 16'hFFFF)
                contPop <= contPop + 16'd1;
            if (descarta && contDesc != 16'hFFFF)
                contDesc <= contDesc + 16'd1;
        end
    end

    assign contInstr = {contDesc, contPop};
`endif
endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: in-order memory model with programmable latency, hand-computed expectations.
module tb_busca_instrucao;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    busca_instrucao_if #(.LARGURA_PC(32)) bus ();
`ifdef BUSCA_CONTADORES_EN
    logic [31:0] contInstr;
`endif

    busca_instrucao #(
        .LARGURA_PC  (32),
        .PROFUNDIDADE(4),
        .PC_INICIAL  (32'h0000_0000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
`ifdef BUSCA_CONTADORES_EN
        ,
        .contInstr(contInstr)
`endif
    );

    int erros = 0;
    int total = 0;
    int cyc   = 0;
    int lat   = 1;
    logic [31:0] filaEnd[$];
    int          filaPronto[$];
    logic [31:0] w;

    function automatic logic [31:0] dado(input logic [31:0] a);
        return a ^ 32'h9C00_002A;
    endfunction

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    // One clock: record this cycle's transfer, advance, then present any due response.
    task automatic passo();
        #1;
        if (bus.memReq && bus.memAceito) begin
            filaEnd.push_back(bus.memEnd);
            filaPronto.push_back(cyc + lat);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (filaPronto.size() > 0 && filaPronto[0] <= cyc) begin
            bus.memValido = 1'b1;
            bus.memDado   = dado(filaEnd[0]);
            void'(filaEnd.pop_front());
            void'(filaPronto.pop_front());
        end else begin
            bus.memValido = 1'b0;
            bus.memDado   = 32'h0;
        end
        #1;
    endtask

    task automatic aplicaReset();
        reset_n        = 1'b0;
        bus.memValido  = 1'b0;
        bus.memDado    = 32'h0;
        bus.memAceito  = 1'b1;
        bus.desvio     = 1'b0;
        bus.alvoDesvio = 32'h0;
        filaEnd.delete();
        filaPronto.delete();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic soltaReset();
        reset_n = 1'b1;
        cyc     = 0;
        #1;
    endtask

    initial begin
        bus.decPronto = 1'b1;
        // Reset state and streaming with zero-wait memory.
        aplicaReset();
        verifica("rst_memReq", 32'(bus.memReq), 32'd0);
        verifica("rst_instrValida", 32'(bus.instrValida), 32'd0);
        verifica("rst_instrucao", bus.instrucao, 32'h0);
        verifica("rst_instrPC", bus.instrPC, 32'h0);
        verifica("rst_opCode", 32'(bus.opCode), 32'd0);
        verifica("rst_funct", 32'(bus.funct), 32'd0);
        soltaReset();
        verifica("c0_memReq", 32'(bus.memReq), 32'd1);
        verifica("c0_memEnd", bus.memEnd, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            passo();
            if (k == 1) begin
                verifica("c1_vazio", 32'(bus.instrValida), 32'd0);
            end else begin
                w = dado(32'((k - 2) * 4));
                verifica("fluxo_valida", 32'(bus.instrValida), 32'd1);
                verifica("fluxo_pc", bus.instrPC, 32'((k - 2) * 4));
                verifica("fluxo_opCode", 32'(bus.opCode), 32'(w[31:26]));
                verifica("fluxo_funct", 32'(bus.funct), 32'(w[5:0]));
            end
        end

        // Decode stalled: exactly four requests, then drain and resume at 0x10.
        aplicaReset();
        bus.decPronto = 1'b0;
        soltaReset();
        begin
            int nReq = 0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if (bus.memReq && bus.memAceito) nReq++;
                passo();
            end
            verifica("cheio_nreq", 32'(nReq), 32'd4);
        end
        verifica("cheio_memReq", 32'(bus.memReq), 32'd0);
        verifica("cheio_estavel", bus.instrPC, 32'h0);
        bus.decPronto = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            verifica("dreno_pc", bus.instrPC, 32'(k * 4));
            if (k == 1) begin
                verifica("retoma_memReq", 32'(bus.memReq), 32'd1);
                verifica("retoma_memEnd", bus.memEnd, 32'h10);
            end
            passo();
        end

        // Latency 3, redirect with two responses in flight.
        aplicaReset();
        bus.decPronto = 1'b0;
        lat = 3;
        soltaReset();
        passo();
        passo();
        bus.memAceito  = 1'b0;
        bus.desvio     = 1'b1;
        bus.alvoDesvio = 32'h103;
        #1;
        verifica("desvio_semReq", 32'(bus.memReq), 32'd0);
        passo();
        bus.desvio    = 1'b0;
        bus.memAceito = 1'b1;
        #1;
        verifica("pos_desvio_memReq", 32'(bus.memReq), 32'd1);
        verifica("pos_desvio_memEnd", bus.memEnd, 32'h100);
        for (int k = 3; k <= 6; k++) begin
            verifica("descarte_vazio", 32'(bus.instrValida), 32'd0);
            passo();
        end
        verifica("alvo_valida", 32'(bus.instrValida), 32'd1);
        verifica("alvo_pc", bus.instrPC, 32'h100);
        verifica("alvo_instrucao", bus.instrucao, dado(32'h100));
        lat = 1;

        // Redirect in the same cycle as a pop and a response.
        aplicaReset();
        bus.decPronto = 1'b1;
        soltaReset();
        passo();
        passo();
        verifica("simult_pc", bus.instrPC, 32'h0);
        verifica("simult_resp", 32'(bus.memValido), 32'd1);
        bus.desvio     = 1'b1;
        bus.alvoDesvio = 32'h200;
        passo();
        bus.desvio = 1'b0;
        #1;
        verifica("simult_vazio", 32'(bus.instrValida), 32'd0);
        verifica("simult_memEnd", bus.memEnd, 32'h200);
`ifdef BUSCA_CONTADORES_EN
        verifica("contInstr", contInstr, 32'h0001_0001);
`endif
        passo();
        verifica("simult_vazio2", 32'(bus.instrValida), 32'd0);
        passo();
        verifica("simult_alvo_pc", bus.instrPC, 32'h200);

        // PC wraps past 0xFFFF_FFFC; low target bits ignored.
        bus.desvio     = 1'b1;
        bus.alvoDesvio = 32'hFFFF_FFFF;
        passo();
        bus.desvio = 1'b0;
        #1;
        verifica("wrap_end0", bus.memEnd, 32'hFFFF_FFFC);
        passo();
        verifica("wrap_end1", bus.memEnd, 32'h0000_0000);
        passo();
        verifica("wrap_pc0", bus.instrPC, 32'hFFFF_FFFC);
        passo();
        verifica("wrap_pc1", bus.instrPC, 32'h0);
        verifica("wrap_instrucao", bus.instrucao, dado(32'h0));

        // Async reset with the FIFO full.
        bus.decPronto = 1'b0;
        repeat (8) passo();
        verifica("cheio_pre_rst", 32'(bus.instrValida), 32'd1);
        reset_n = 1'b0;
        #1;
        verifica("rst_async_valida", 32'(bus.instrValida), 32'd0);
        verifica("rst_async_instrucao", bus.instrucao, 32'h0);
        verifica("rst_async_ocupacao", 32'(dut.ocupacao), 32'd0);
        verifica("rst_async_memReq", 32'(bus.memReq), 32'd0);
        aplicaReset();
        bus.decPronto = 1'b1;
        soltaReset();
        verifica("reinicio_memEnd", bus.memEnd, 32'h0);
        passo();
        passo();
        verifica("reinicio_pc", bus.instrPC, 32'h0);

        $display("Result: errors=%0d of %0d checks", erros, total);
        $finish;
    end
endmodule
